// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared encodings and types for the register-file port arbiter
package regfile_port_arbiter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;
    localparam int WCMD_WIDTH = 3;

    // Register-file writeCommand encodings
    localparam logic [WCMD_WIDTH-1:0] WCMD_NONE        = 3'b000;
    localparam logic [WCMD_WIDTH-1:0] WCMD_STATUS      = 3'b001;
    localparam logic [WCMD_WIDTH-1:0] WCMD_FILE        = 3'b010;
    localparam logic [WCMD_WIDTH-1:0] WCMD_FILE_STATUS = 3'b011;

    // Special file addresses
    localparam logic [ADDR_WIDTH-1:0] ADDR_INDF   = 5'h00;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = 5'h03;
    localparam logic [ADDR_WIDTH-1:0] ADDR_FSR    = 5'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT,
        ST_ACK
    } arb_state_t;

    // Debug never produces status side effects: plain file write or nothing
    function automatic logic [WCMD_WIDTH-1:0] dbg_wcmd(input logic we);
        return we ? WCMD_FILE : WCMD_NONE;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - core, debug and register-file port bundle
interface regfile_port_arbiter_if;
    import regfile_port_arbiter_pkg::*;

    // Core side
    logic                  core_valid;
    logic [WCMD_WIDTH-1:0] core_write_cmd;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  core_stall;

    // Debug/host side
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    // Register-file side
    logic [WCMD_WIDTH-1:0] rf_write_cmd;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rf_rdata;

    // Arbiter view
    modport slave (
        input  core_valid, core_write_cmd, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output rf_write_cmd, rf_addr, rf_wdata,
        input  rf_rdata
    );

    // Environment view (core, debug host and register file)
    modport master (
        output core_valid, core_write_cmd, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  rf_write_cmd, rf_addr, rf_wdata,
        output rf_rdata
    );

endinterface

// File: rtl/regfile_starve_counter.sv
// rtl/regfile_starve_counter.sv - saturating count of denied debug cycles
module regfile_starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_limit
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(STARVE_LIMIT));
    assign o_limit    = w_at_limit;

    // Count denied cycles, hold at the limit, clear on grant or abandon
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares the register-file port between core and debug
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_port_arbiter_if.slave  bus
);

    arb_state_t            r_state;
    logic                  r_dbg_ack;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;

    logic w_waiting;
    logic w_grant;
    logic w_steal;
    logic w_abort;
    logic w_cnt_inc;
    logic w_cnt_clr;
    logic w_limit;

    // Debug may only take an idle core cycle, except in the forced GRANT slot
    assign w_waiting = (r_state == ST_IDLE) || (r_state == ST_WAIT);
    assign w_steal   = bus.dbg_req && (r_state == ST_GRANT);
    assign w_grant   = (bus.dbg_req && w_waiting && !bus.core_valid) || w_steal;
    assign w_abort   = !bus.dbg_req && ((r_state == ST_WAIT) || (r_state == ST_GRANT));
    assign w_cnt_inc = bus.dbg_req && bus.core_valid && w_waiting;
    assign w_cnt_clr = w_grant || w_abort;

    regfile_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_limit (w_limit)
    );

    // Port mux: debug owns the port only in its grant cycle; writes are dropped while in reset
    always_comb begin
        bus.rf_write_cmd = WCMD_NONE;
        bus.rf_addr      = bus.core_addr;
        bus.rf_wdata     = bus.core_wdata;
        if (w_grant) begin
            bus.rf_write_cmd = dbg_wcmd(bus.dbg_we);
            bus.rf_addr      = bus.dbg_addr;
            bus.rf_wdata     = bus.dbg_wdata;
        end else if (bus.core_valid) begin
            bus.rf_write_cmd = bus.core_write_cmd;
        end
        if (!rst) begin
            bus.rf_write_cmd = WCMD_NONE;
        end
    end

    // Opportunistic grants only happen with core_valid low, so only the stolen slot stalls
    assign bus.core_stall = w_steal;
    assign bus.core_rdata = bus.rf_rdata;
    assign bus.dbg_ack    = r_dbg_ack;
    assign bus.dbg_rdata  = r_dbg_rdata;

    // Request/grant/ack sequencing with read-data capture at the end of the grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else if (w_grant) begin
            r_dbg_rdata <= bus.rf_rdata;
            r_dbg_ack   <= 1'b1;
            r_state     <= ST_ACK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.dbg_req) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.dbg_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_limit) begin
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_IDLE;
                end
                ST_ACK: begin
                    if (!bus.dbg_req) begin
                        r_state   <= ST_IDLE;
                        r_dbg_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
